// File: rtl/alu_multicycle_pkg.sv
// Shared types and range helpers for the multi-cycle picoMIPS ALU.
// Values are carried as 64-bit signed intermediates so one helper serves any N up to 32.
package cpuConfig;

  typedef enum logic [2:0] {
    ALU_A   = 3'd0,
    ALU_ADD = 3'd1,
    ALU_MUL = 3'd2,
    ALU_B   = 3'd3,
    ALU_SUB = 3'd4
  } aluFunc_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } aluState_t;

  function automatic logic overflows(input logic signed [63:0] v, input int unsigned n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int unsigned n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/alu_multicycle_mul.sv
// Unsigned N x N iterative shift-add multiplier: one partial product per step.
module seq_mul #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 load,
  input  logic                 step,
  input  logic [N-1:0]         mcand,
  input  logic [N-1:0]         mplier,
  output logic [$clog2(N)-1:0] count,
  output logic [2*N-1:0]       product
);
  localparam int CW = $clog2(N);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand_sh;
  logic [N-1:0]   mplier_sh;

  // Accumulator value after the step taken at the coming edge; on the final step
  // this is the full product, letting the caller register it in the same edge.
  always_comb begin
    product = mplier_sh[0] ? acc + mcand_sh : acc;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      count     <= '0;
    end else if (load) begin
      acc       <= '0;
      mcand_sh  <= {{N{1'b0}}, mcand};
      mplier_sh <= mplier;
      count     <= CW'(N - 1);
    end else if (step) begin
      acc       <= product;
      mcand_sh  <= mcand_sh << 1;
      mplier_sh <= mplier_sh >> 1;
      count     <= count - CW'(1);
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU: single-cycle A/B/ADD/SUB, N-cycle fixed-point MUL (a is Q(N-F).F, b integer).
// Owns the FSM, sign handling, scaling by F, saturation and the registered flags.
module alu_multicycle
  import cpuConfig::*;
#(
  parameter int N   = 8,
  parameter int F   = 7,
  parameter int SAT = 1
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  aluFunc_t     func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);
  aluState_t state;
  logic      sign_q;

  logic                 mul_load;
  logic                 mul_step;
  logic [N-1:0]         mag_a;
  logic [N-1:0]         mag_b;
  logic [$clog2(N)-1:0] mul_count;
  logic [2*N-1:0]       mul_product;

  logic signed [63:0] a_ext, b_ext, op_val, mul_val, fin_val, sat_val, sel_val;
  logic [63:0]        mul_mag;
  logic [2*N-1:0]     mul_scaled;
  logic               op_chk, fin_chk, fin_ovf;
  logic [N-1:0]       fin_res;

  assign mul_load = (state == IDLE) && start && (func == ALU_MUL);
  assign mul_step = (state == MUL);

  always_comb begin
    mag_a = a[N-1] ? -a : a;
    mag_b = b[N-1] ? -b : b;
  end

  seq_mul #(.N(N)) u_mul (
    .clk     (clk),
    .nReset  (nReset),
    .load    (mul_load),
    .step    (mul_step),
    .mcand   (mag_a),
    .mplier  (mag_b),
    .count   (mul_count),
    .product (mul_product)
  );

  always_comb begin
    a_ext  = 64'(signed'(a));
    b_ext  = 64'(signed'(b));
    op_val = '0;
    op_chk = 1'b0;
    case (func)
      ALU_A:   op_val = a_ext;
      ALU_B:   op_val = b_ext;
      ALU_ADD: begin op_val = a_ext + b_ext; op_chk = 1'b1; end
      ALU_SUB: begin op_val = a_ext - b_ext; op_chk = 1'b1; end
      default: op_val = '0;
    endcase

    // Scale the magnitude first so truncation is toward zero, then restore the sign.
    mul_scaled = mul_product >> F;
    mul_mag    = 64'(mul_scaled);
    mul_val    = sign_q ? -signed'(mul_mag) : signed'(mul_mag);

    fin_val = (state == MUL) ? mul_val : op_val;
    fin_chk = (state == MUL) ? 1'b1 : op_chk;
    fin_ovf = fin_chk && overflows(fin_val, N);
    sat_val = saturate(fin_val, N);
    sel_val = ((SAT != 0) && fin_ovf) ? sat_val : fin_val;
    fin_res = N'(sel_val);
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (func == ALU_MUL) begin
              state  <= MUL;
              busy   <= 1'b1;
              sign_q <= a[N-1] ^ b[N-1];
            end else begin
              done   <= 1'b1;
              result <= fin_res;
              zero   <= (fin_res == '0);
              neg    <= fin_res[N-1];
              ovf    <= fin_ovf;
            end
          end
        end
        MUL: begin
          if (mul_count == '0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin_res;
            zero   <= (fin_res == '0);
            neg    <= fin_res[N-1];
            ovf    <= fin_ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench: saturating and wrapping instances against an integer reference model.
module tb_alu_multicycle;
  import cpuConfig::*;

  logic       clk = 1'b0;
  logic       nReset;
  logic       start;
  aluFunc_t   func;
  logic [7:0] a, b;

  logic       busy, done, zero, neg, ovf;
  logic [7:0] result;
  logic       busy_w, done_w, zero_w, neg_w, ovf_w;
  logic [7:0] result_w;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.N(8), .F(7), .SAT(1)) dut (
    .clk(clk), .nReset(nReset), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_multicycle #(.N(8), .F(7), .SAT(0)) dut_w (
    .clk(clk), .nReset(nReset), .start(start), .func(func), .a(a), .b(b),
    .busy(busy_w), .done(done_w), .result(result_w), .zero(zero_w), .neg(neg_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the signed operand values.
  function automatic void model(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                                input bit sat, output logic [7:0] res, output bit ov);
    int xv, yv, v, p, m;
    xv = int'($signed(x));
    yv = int'($signed(y));
    case (f)
      3'd0: v = xv;
      3'd1: v = xv + yv;
      3'd2: begin
        p = xv * yv;
        m = (p < 0 ? -p : p) / 128;
        v = (p < 0) ? -m : m;
      end
      3'd3: v = yv;
      3'd4: v = xv - yv;
      default: v = 0;
    endcase
    ov = (v > 127) || (v < -128);
    if (ov && sat) v = (v > 0) ? 127 : -128;
    res = 8'(v);
  endfunction

  task automatic issue(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    func  = aluFunc_t'(f);
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] er, erw;
    bit         eo, eow;
    int         lat, busy_n, exp_lat;
    model(f, x, y, 1'b1, er, eo);
    model(f, x, y, 1'b0, erw, eow);
    exp_lat = (f == 3'd2) ? 8 : 0;
    issue(f, x, y);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL latency f=%0d a=%h b=%h: got %0d want %0d", f, x, y, lat, exp_lat);
    end
    total++;
    if (busy_n !== exp_lat) begin
      bad++;
      $display("FAIL busy_cycles f=%0d a=%h b=%h: got %0d want %0d", f, x, y, busy_n, exp_lat);
    end
    total++;
    if ({result, zero, neg, ovf, busy} !== {er, er == 8'd0, er[7], eo, 1'b0}) begin
      bad++;
      $display("FAIL sat_out f=%0d a=%h b=%h: got r=%h z=%b n=%b o=%b bsy=%b want r=%h z=%b n=%b o=%b",
               f, x, y, result, zero, neg, ovf, busy, er, er == 8'd0, er[7], eo);
    end
    total++;
    if ({done_w, result_w, ovf_w} !== {1'b1, erw, eow}) begin
      bad++;
      $display("FAIL wrap_out f=%0d a=%h b=%h: got d=%b r=%h o=%b want d=1 r=%h o=%b",
               f, x, y, done_w, result_w, ovf_w, erw, eow);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse f=%0d: got %b want 0", f, done);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    start  = 1'b0;
    func   = ALU_A;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, zero, neg, ovf} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got bsy=%b d=%b r=%h z=%b n=%b o=%b want all 0",
               busy, done, result, zero, neg, ovf);
    end
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd1, 8'd10, 8'd5);
    run_op(3'd2, 8'h60, 8'd6);
    run_op(3'd2, 8'hC0, 8'd5);
    run_op(3'd2, 8'hC0, 8'd0);
    run_op(3'd1, 8'd100, 8'd100);
    run_op(3'd4, 8'h80, 8'd1);
    run_op(3'd2, 8'h80, 8'h80);
    run_op(3'd0, 8'h9A, 8'h11);
    run_op(3'd3, 8'h9A, 8'h11);
    run_op(3'd6, 8'h12, 8'h34);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_busy_ignore();
    int dones, guard;
    logic [7:0] res_seen;
    issue(3'd2, 8'h60, 8'd6);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    func  = ALU_ADD;
    a     = 8'd1;
    b     = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    res_seen = '0;
    for (guard = 0; guard < 16; guard++) begin
      if (done) begin
        dones++;
        res_seen = result;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL busy_ignore_dones: got %0d want 1", dones);
    end
    total++;
    if (res_seen !== 8'd4) begin
      bad++;
      $display("FAIL busy_ignore_result: got %h want 04", res_seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(3'd2, 8'hC0, 8'd5);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (result !== 8'hFE || lat !== 8) begin
      bad++;
      $display("FAIL b2b_mul: got r=%h lat=%0d want r=fe lat=8", result, lat);
    end
    start = 1'b1;
    func  = ALU_ADD;
    a     = 8'd3;
    b     = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if ({done, result, busy} !== {1'b1, 8'd7, 1'b0}) begin
      bad++;
      $display("FAIL b2b_add: got d=%b r=%h bsy=%b want d=1 r=07 bsy=0", done, result, busy);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    issue(3'd2, 8'h60, 8'd6);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, zero, neg, ovf} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got bsy=%b d=%b r=%h z=%b n=%b o=%b want all 0",
               busy, done, result, zero, neg, ovf);
    end
    @(negedge clk);
    nReset = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d active cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
